// File: rtl/arcade_input_mapper.sv
// Arcade input conditioner: PS/2 + joystick merge, orientation remap, timed coin pulses.
// Optional ARCADE_INPUT_SOCD_EN: opposite directions pressed together cancel to neither.
module arcade_input_mapper #(
  parameter int PLAYERS    = 2,
  parameter int COIN_LEN   = 8,
  parameter int COIN_GAP   = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    tick,
  input  logic [10:0]             ps2_key,
  input  logic [16*PLAYERS-1:0]   joy,
  input  logic                    rotate,
  output logic [PLAYERS-1:0]      p_up,
  output logic [PLAYERS-1:0]      p_down,
  output logic [PLAYERS-1:0]      p_left,
  output logic [PLAYERS-1:0]      p_right,
  output logic [PLAYERS-1:0]      p_fire,
  output logic                    start1,
  output logic                    start2,
  output logic                    coin,
  output logic [1:0]              dbg_coin_state
);

  localparam logic       POL    = (ACTIVE_LOW != 0);
  localparam logic [7:0] LEN_M1 = 8'(COIN_LEN - 1);
  localparam logic [7:0] GAP_M1 = 8'(COIN_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } coin_state_t;

  // Keyboard key state, always active-high internally.
  logic r_toggle;
  logic r_key_up, r_key_down, r_key_left, r_key_right;
  logic r_key_space, r_key_ctrl, r_key_start1, r_key_start2, r_key_coin;
  logic w_evt;

  assign w_evt = (ps2_key[10] != r_toggle);

  always_ff @(posedge CLK) begin
    r_toggle <= ps2_key[10];
    if (RESET) begin
      r_key_up     <= 1'b0;
      r_key_down   <= 1'b0;
      r_key_left   <= 1'b0;
      r_key_right  <= 1'b0;
      r_key_space  <= 1'b0;
      r_key_ctrl   <= 1'b0;
      r_key_start1 <= 1'b0;
      r_key_start2 <= 1'b0;
      r_key_coin   <= 1'b0;
    end else if (w_evt) begin
      case (ps2_key[7:0])
        8'h75:   r_key_up     <= ps2_key[9];
        8'h72:   r_key_down   <= ps2_key[9];
        8'h6B:   r_key_left   <= ps2_key[9];
        8'h74:   r_key_right  <= ps2_key[9];
        8'h29:   r_key_space  <= ps2_key[9];
        8'h14:   r_key_ctrl   <= ps2_key[9];
        8'h05:   r_key_start1 <= ps2_key[9];
        8'h06:   r_key_start2 <= ps2_key[9];
        8'h2E:   r_key_coin   <= ps2_key[9];
        default: ;
      endcase
    end
  end

  // Merge keyboard into player 0, then remap orientation.
  logic [PLAYERS-1:0] w_m_up, w_m_down, w_m_left, w_m_right, w_m_fire;
  logic [PLAYERS-1:0] w_r_up, w_r_down, w_r_left, w_r_right;
  logic [PLAYERS-1:0] w_f_up, w_f_down, w_f_left, w_f_right;
  logic               w_start1, w_start2, w_joy_coin, w_unused;

  always_comb begin
    w_m_up     = '0;
    w_m_down   = '0;
    w_m_left   = '0;
    w_m_right  = '0;
    w_m_fire   = '0;
    w_start1   = r_key_start1;
    w_start2   = r_key_start2;
    w_joy_coin = 1'b0;
    w_unused   = ps2_key[8];
    for (int p = 0; p < PLAYERS; p++) begin
      w_m_right[p] = joy[16*p+0];
      w_m_left[p]  = joy[16*p+1];
      w_m_down[p]  = joy[16*p+2];
      w_m_up[p]    = joy[16*p+3];
      w_m_fire[p]  = joy[16*p+4];
      w_start1     = w_start1   | joy[16*p+5];
      w_start2     = w_start2   | joy[16*p+6];
      w_joy_coin   = w_joy_coin | joy[16*p+7];
      w_unused     = w_unused ^ (^joy[16*p+8 +: 8]);
      if (p == 0) begin
        w_m_right[p] = w_m_right[p] | r_key_right;
        w_m_left[p]  = w_m_left[p]  | r_key_left;
        w_m_down[p]  = w_m_down[p]  | r_key_down;
        w_m_up[p]    = w_m_up[p]    | r_key_up;
        w_m_fire[p]  = w_m_fire[p]  | r_key_space | r_key_ctrl;
      end
    end
  end

  assign w_r_up    = rotate ? w_m_left  : w_m_up;
  assign w_r_down  = rotate ? w_m_right : w_m_down;
  assign w_r_left  = rotate ? w_m_down  : w_m_left;
  assign w_r_right = rotate ? w_m_up    : w_m_right;

`ifdef ARCADE_INPUT_SOCD_EN
  assign w_f_up    = w_r_up    & ~w_r_down;
  assign w_f_down  = w_r_down  & ~w_r_up;
  assign w_f_left  = w_r_left  & ~w_r_right;
  assign w_f_right = w_r_right & ~w_r_left;
`else
  assign w_f_up    = w_r_up;
  assign w_f_down  = w_r_down;
  assign w_f_left  = w_r_left;
  assign w_f_right = w_r_right;
`endif

  // Output flops hold the final core-ready polarity.
  logic [PLAYERS-1:0] r_p_up, r_p_down, r_p_left, r_p_right, r_p_fire;
  logic               r_start1, r_start2;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_p_up    <= {PLAYERS{POL}};
      r_p_down  <= {PLAYERS{POL}};
      r_p_left  <= {PLAYERS{POL}};
      r_p_right <= {PLAYERS{POL}};
      r_p_fire  <= {PLAYERS{POL}};
      r_start1  <= POL;
      r_start2  <= POL;
    end else begin
      r_p_up    <= w_f_up    ^ {PLAYERS{POL}};
      r_p_down  <= w_f_down  ^ {PLAYERS{POL}};
      r_p_left  <= w_f_left  ^ {PLAYERS{POL}};
      r_p_right <= w_f_right ^ {PLAYERS{POL}};
      r_p_fire  <= w_m_fire  ^ {PLAYERS{POL}};
      r_start1  <= w_start1  ^ POL;
      r_start2  <= w_start2  ^ POL;
    end
  end

  // Coin FSM: request is a rising edge of any coin-capable source.
  coin_state_t r_state;
  logic [7:0]  r_cnt;
  logic        r_pending, r_coin, r_coin_src_q;
  logic        w_coin_src, w_req;

  assign w_coin_src = w_start1 | w_start2 | r_key_coin | w_joy_coin;
  assign w_req      = w_coin_src & ~r_coin_src_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_pending    <= 1'b0;
      r_coin       <= POL;
      r_coin_src_q <= 1'b0;
    end else begin
      r_coin_src_q <= w_coin_src;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_state <= S_PULSE;
            r_cnt   <= 8'd0;
            r_coin  <= ~POL;
          end
        end
        S_PULSE: begin
          if (w_req) r_pending <= 1'b1;
          if (tick) begin
            if (r_cnt == LEN_M1) begin
              r_state <= S_GAP;
              r_cnt   <= 8'd0;
              r_coin  <= POL;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        S_GAP: begin
          if (w_req) r_pending <= 1'b1;
          if (tick) begin
            if (r_cnt == GAP_M1) begin
              r_cnt <= 8'd0;
              // A request landing on the exit tick still launches the next pulse.
              if (r_pending || w_req) begin
                r_state   <= S_PULSE;
                r_pending <= 1'b0;
                r_coin    <= ~POL;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 8'd0;
          r_coin  <= POL;
        end
      endcase
    end
  end

  assign p_up           = r_p_up;
  assign p_down         = r_p_down;
  assign p_left         = r_p_left;
  assign p_right        = r_p_right;
  assign p_fire         = r_p_fire;
  assign start1         = r_start1;
  assign start2         = r_start2;
  assign coin           = r_coin;
  assign dbg_coin_state = r_state;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper (PLAYERS=2, COIN_LEN=3, COIN_GAP=2, active-low outputs).
module tb_arcade_input_mapper;

  localparam int PLAYERS    = 2;
  localparam int COIN_LEN   = 3;
  localparam int COIN_GAP   = 2;
  localparam int ACTIVE_LOW = 1;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic                  CLK = 1'b0;
  logic                  RESET;
  logic                  tick;
  logic [10:0]           ps2_key;
  logic [16*PLAYERS-1:0] joy;
  logic                  rotate;
  logic [PLAYERS-1:0]    p_up, p_down, p_left, p_right, p_fire;
  logic                  start1, start2, coin;
  logic [1:0]            dbg_coin_state;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic tick_en = 1'b0;
  int   hi_ticks, gap_ticks, pulses;
  logic prev_coin_on = 1'b0;

  arcade_input_mapper #(
    .PLAYERS(PLAYERS), .COIN_LEN(COIN_LEN), .COIN_GAP(COIN_GAP), .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .tick(tick), .ps2_key(ps2_key), .joy(joy), .rotate(rotate),
    .p_up(p_up), .p_down(p_down), .p_left(p_left), .p_right(p_right), .p_fire(p_fire),
    .start1(start1), .start2(start2), .coin(coin), .dbg_coin_state(dbg_coin_state)
  );

  always #5 CLK = ~CLK;

  // Advance n cycles; tick pulses every 4th cycle when enabled, coin activity is tallied.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      if (tick && coin === 1'b0) hi_ticks++;
      if (tick && dbg_coin_state === ST_GAP) gap_ticks++;
      @(posedge CLK);
      #1;
      cyc++;
      if (coin === 1'b0 && !prev_coin_on) pulses++;
      prev_coin_on = (coin === 1'b0);
      tick = tick_en && (cyc % 4 == 0);
    end
  endtask

  task automatic ps2_send(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  task automatic coin_req();
    joy[23] = 1'b1;
    step(1);
    joy[23] = 1'b0;
    step(1);
  endtask

  task automatic clear_counts();
    hi_ticks  = 0;
    gap_ticks = 0;
    pulses    = 0;
  endtask

  task automatic test_reset();
    RESET   = 1'b1;
    ps2_key = 11'h000;
    joy     = '0;
    rotate  = 1'b0;
    tick    = 1'b0;
    step(3);
    ps2_send(1'b1, 1'b0, 8'h75);
    step(1);
    checks++;
    if (p_up !== 2'b11 || coin !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold: p_up=%b coin=%b required p_up=11 coin=1", p_up, coin);
    end
    RESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++;
      if ({p_up, p_down, p_left, p_right, p_fire, start1, start2, coin} !== 13'h1FFF ||
          dbg_coin_state !== ST_IDLE) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: outs=%h state=%0d required 1fff state 0", i,
                 {p_up, p_down, p_left, p_right, p_fire, start1, start2, coin}, dbg_coin_state);
      end
    end
  endtask

  task automatic test_ps2_keys();
    ps2_send(1'b1, 1'b0, 8'h75);
    step(1);
    checks++;
    if (p_up[0] !== 1'b1) begin
      errors++;
      $display("FAIL ps2_up_early: p_up[0]=%b required 1", p_up[0]);
    end
    step(1);
    checks++;
    if (p_up !== 2'b10) begin
      errors++;
      $display("FAIL ps2_up_press: p_up=%b required 10", p_up);
    end
    ps2_send(1'b0, 1'b0, 8'h75);
    step(1);
    checks++;
    if (p_up[0] !== 1'b0) begin
      errors++;
      $display("FAIL ps2_up_hold: p_up[0]=%b required 0", p_up[0]);
    end
    step(1);
    checks++;
    if (p_up[0] !== 1'b1) begin
      errors++;
      $display("FAIL ps2_up_release: p_up[0]=%b required 1", p_up[0]);
    end
    ps2_key = {ps2_key[10], 1'b1, 1'b0, 8'h75};
    step(3);
    checks++;
    if (p_up[0] !== 1'b1) begin
      errors++;
      $display("FAIL ps2_same_toggle: p_up[0]=%b required 1", p_up[0]);
    end
    ps2_send(1'b1, 1'b1, 8'h6B);
    step(2);
    ps2_send(1'b1, 1'b0, 8'h14);
    step(2);
    ps2_send(1'b1, 1'b0, 8'h1C);
    step(2);
    checks++;
    if (p_left !== 2'b10 || p_fire !== 2'b10 || p_up !== 2'b11 || p_down !== 2'b11 ||
        p_right !== 2'b11) begin
      errors++;
      $display("FAIL ps2_left_ctrl: l=%b f=%b u=%b d=%b r=%b required l=10 f=10 u/d/r=11",
               p_left, p_fire, p_up, p_down, p_right);
    end
    ps2_send(1'b0, 1'b1, 8'h6B);
    step(2);
    ps2_send(1'b0, 1'b0, 8'h14);
    step(2);
    checks++;
    if (p_left !== 2'b11 || p_fire !== 2'b11) begin
      errors++;
      $display("FAIL ps2_released: l=%b f=%b required 11 11", p_left, p_fire);
    end
  endtask

  task automatic test_rotate();
    rotate = 1'b1;
    joy[1] = 1'b1;
    step(1);
    checks++;
    if (p_up !== 2'b10 || p_left !== 2'b11) begin
      errors++;
      $display("FAIL rotate_left_to_up: p_up=%b p_left=%b required 10 11", p_up, p_left);
    end
    joy[4]  = 1'b1;
    joy[16] = 1'b1;
    step(1);
    checks++;
    if (p_fire !== 2'b10 || p_down !== 2'b01 || p_right !== 2'b11) begin
      errors++;
      $display("FAIL rotate_fire_p1: p_fire=%b p_down=%b p_right=%b required 10 01 11",
               p_fire, p_down, p_right);
    end
    joy    = '0;
    rotate = 1'b0;
    step(1);
    checks++;
    if (p_up !== 2'b11 || p_down !== 2'b11 || p_fire !== 2'b11) begin
      errors++;
      $display("FAIL rotate_clear: u=%b d=%b f=%b required 11", p_up, p_down, p_fire);
    end
  endtask

  task automatic test_coin_f1();
    int guard;
    tick_en = 1'b1;
    clear_counts();
    ps2_send(1'b1, 1'b0, 8'h05);
    step(1);
    checks++;
    if (start1 !== 1'b1 || coin !== 1'b1) begin
      errors++;
      $display("FAIL f1_early: start1=%b coin=%b required 1 1", start1, coin);
    end
    step(1);
    checks++;
    if (start1 !== 1'b0 || coin !== 1'b0) begin
      errors++;
      $display("FAIL f1_press: start1=%b coin=%b required 0 0", start1, coin);
    end
    guard = 0;
    while (dbg_coin_state !== ST_IDLE && guard < 200) begin
      step(1);
      guard++;
    end
    checks++;
    if (guard >= 200 || hi_ticks != COIN_LEN || gap_ticks != COIN_GAP || pulses != 1) begin
      errors++;
      $display("FAIL f1_pulse: hi=%0d gap=%0d pulses=%0d guard=%0d required 3 2 1", hi_ticks,
               gap_ticks, pulses, guard);
    end
    ps2_send(1'b0, 1'b0, 8'h05);
    step(2);
    checks++;
    if (start1 !== 1'b1 || coin !== 1'b1 || dbg_coin_state !== ST_IDLE) begin
      errors++;
      $display("FAIL f1_release: start1=%b coin=%b state=%0d required 1 1 0", start1, coin,
               dbg_coin_state);
    end
  endtask

  task automatic test_coin_pending();
    int guard;
    clear_counts();
    coin_req();
    coin_req();
    coin_req();
    checks++;
    if (dbg_coin_state !== ST_PULSE || coin !== 1'b0) begin
      errors++;
      $display("FAIL pend_in_pulse: state=%0d coin=%b required 1 0", dbg_coin_state, coin);
    end
    guard = 0;
    while (dbg_coin_state !== ST_GAP && guard < 50) begin
      step(1);
      guard++;
    end
    coin_req();
    guard = 0;
    while (dbg_coin_state !== ST_IDLE && guard < 200) begin
      step(1);
      guard++;
    end
    checks++;
    if (guard >= 200 || pulses != 2 || hi_ticks != 2 * COIN_LEN || gap_ticks != 2 * COIN_GAP)
    begin
      errors++;
      $display("FAIL pend_pulses: pulses=%0d hi=%0d gap=%0d guard=%0d required 2 6 4", pulses,
               hi_ticks, gap_ticks, guard);
    end
    tick_en = 1'b0;
    step(1);
  endtask

  task automatic test_socd();
    joy[3:1] = 3'b111;
    step(1);
`ifdef ARCADE_INPUT_SOCD_EN
    checks++;
    if (p_up[0] !== 1'b1 || p_down[0] !== 1'b1 || p_left[0] !== 1'b0) begin
      errors++;
      $display("FAIL socd: u=%b d=%b l=%b required 1 1 0", p_up[0], p_down[0], p_left[0]);
    end
`else
    checks++;
    if (p_up[0] !== 1'b0 || p_down[0] !== 1'b0 || p_left[0] !== 1'b0) begin
      errors++;
      $display("FAIL socd: u=%b d=%b l=%b required 0 0 0", p_up[0], p_down[0], p_left[0]);
    end
`endif
    joy = '0;
    step(1);
  endtask

  task automatic test_merge();
    joy[22] = 1'b1;
    joy[17] = 1'b1;
    step(1);
    checks++;
    if (start2 !== 1'b0 || start1 !== 1'b1 || p_left !== 2'b01) begin
      errors++;
      $display("FAIL merge_p1: start2=%b start1=%b p_left=%b required 0 1 01", start2, start1,
               p_left);
    end
    step(1);
    checks++;
    if (coin !== 1'b0 || dbg_coin_state !== ST_PULSE) begin
      errors++;
      $display("FAIL merge_coin: coin=%b state=%0d required 0 1", coin, dbg_coin_state);
    end
    joy = '0;
    step(2);
  endtask

  task automatic test_reset_mid_pulse();
    checks++;
    if (coin !== 1'b0) begin
      errors++;
      $display("FAIL mid_pulse_pre: coin=%b required 0", coin);
    end
    RESET = 1'b1;
    step(1);
    checks++;
    if (coin !== 1'b1 || dbg_coin_state !== ST_IDLE || start2 !== 1'b1) begin
      errors++;
      $display("FAIL mid_pulse_reset: coin=%b state=%0d start2=%b required 1 0 1", coin,
               dbg_coin_state, start2);
    end
    RESET = 1'b0;
    step(3);
    checks++;
    if (coin !== 1'b1 || dbg_coin_state !== ST_IDLE) begin
      errors++;
      $display("FAIL mid_pulse_after: coin=%b state=%0d required 1 0", coin, dbg_coin_state);
    end
  endtask

  initial begin
    test_reset();
    test_ps2_keys();
    test_rotate();
    test_coin_f1();
    test_coin_pending();
    test_socd();
    test_merge();
    test_reset_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
